// File: rtl/load_store_unit.sv
// Data-memory initiator: byte/half/word/double loads with sign/zero extension,
// and read-modify-write of the containing doubleword for sub-doubleword stores.
module load_store_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_fault,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    input  logic [DATA_W-1:0]     rd
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t state, state_nx;

    logic                  op_st;
    logic [2:0]            f3;
    logic [2:0]            off;
    logic [DATA_W-1:0]     wdata_q;
    logic                  accept, fault_now;
    logic [DATA_W-1:0]     sh, sz_mask, mask, ld_val, merged;

    logic                  mem_read_nx, mem_write_nx, resp_valid_nx, resp_fault_nx;
    logic [DM_ADDRESS-1:0] a_nx;
    logic [DATA_W-1:0]     wd_nx, resp_rdata_nx;

    // Memory wraps within its own address space; upper address bits are dropped.
    logic unused_hi;
    assign unused_hi = ^req_addr[DATA_W-1:DM_ADDRESS];

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        case (req_funct3[1:0])
            2'b01:   fault_now = req_addr[0];
            2'b10:   fault_now = |req_addr[1:0];
            2'b11:   fault_now = |req_addr[2:0];
            default: fault_now = 1'b0;
        endcase
        if (req_funct3 == 3'b111 || (req_is_store && req_funct3[2]))
            fault_now = 1'b1;
    end

    // Load extraction and store merge both work on the doubleword currently on rd.
    always_comb begin
        sh = rd >> {off, 3'b000};
        case (f3)
            3'b000:  ld_val = {{56{sh[7]}},  sh[7:0]};
            3'b001:  ld_val = {{48{sh[15]}}, sh[15:0]};
            3'b010:  ld_val = {{32{sh[31]}}, sh[31:0]};
            3'b100:  ld_val = {56'b0, sh[7:0]};
            3'b101:  ld_val = {48'b0, sh[15:0]};
            3'b110:  ld_val = {32'b0, sh[31:0]};
            default: ld_val = sh;
        endcase
        case (f3[1:0])
            2'b00:   sz_mask = 64'h0000_0000_0000_00FF;
            2'b01:   sz_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   sz_mask = 64'h0000_0000_FFFF_FFFF;
            default: sz_mask = '1;
        endcase
        mask   = sz_mask << {off, 3'b000};
        merged = (rd & ~mask) | ((wdata_q << {off, 3'b000}) & mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) begin
                if (fault_now)                        state_nx = RESP;
                else if (!req_is_store)               state_nx = RD;
                else if (req_funct3[1:0] == 2'b11)    state_nx = WR;
                else                                  state_nx = RD;
            end
            RD:      state_nx = op_st ? WR : RESP;
            WR:      state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered, so they are glitch-free.
    always_comb begin
        mem_read_nx   = (state_nx == RD);
        mem_write_nx  = (state_nx == WR);
        resp_valid_nx = (state_nx == RESP);
        a_nx          = a;
        wd_nx         = wd;
        resp_rdata_nx = resp_rdata;
        resp_fault_nx = resp_fault;
        if (accept) begin
            a_nx          = req_addr[DM_ADDRESS-1:0];
            resp_rdata_nx = '0;
            resp_fault_nx = fault_now;
            if (!fault_now && req_is_store && req_funct3[1:0] == 2'b11)
                wd_nx = req_wdata;
        end
        if (state == RD) begin
            if (op_st) wd_nx         = merged;
            else       resp_rdata_nx = ld_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_st   <= 1'b0;
            f3      <= '0;
            off     <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_st   <= req_is_store;
            f3      <= req_funct3;
            off     <= req_addr[2:0];
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            a          <= '0;
            wd         <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
        end else begin
            MemRead    <= mem_read_nx;
            MemWrite   <= mem_write_nx;
            a          <= a_nx;
            wd         <= wd_nx;
            resp_valid <= resp_valid_nx;
            resp_rdata <= resp_rdata_nx;
            resp_fault <= resp_fault_nx;
        end
    end
endmodule
